dac_interleave_tx: RTL and testbench



---
 rtl/dac_interleave_tx_pkg.sv | 19 +
 rtl/dac_interleave_tx_sample_fmt.sv | 45 ++++
 rtl/dac_interleave_tx.sv | 177 +++++++++++++++++
 tb/tb_dac_interleave_tx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/dac_interleave_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : dac_tx_pkg
//  Purpose  : Shared constants for the interleaved DAC transmit path.
//             These are the state encodings and the underrun counter width.
//  Revision : 1.0  initial release
// ============================================================================
package dac_tx_pkg;

  // Encodings for the enable/arm state machine
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  // Width of the saturating underrun counter
  localparam int UNDERRUN_W = 16;

endpackage
`default_nettype wire

// File: rtl/dac_interleave_tx_sample_fmt.sv
`default_nettype none
// ============================================================================
//  Module   : dac_sample_fmt
//  Purpose  : Combinational DAC word formatter.
//             It clips a signed sample to the DAC range, optionally converts
//             it to offset binary, and optionally inverts the whole word.
//  Revision : 1.0  initial release
// ============================================================================
module dac_sample_fmt #(
  parameter int DATA_IN_SIZE  = 16,
  parameter int DAC_SIZE      = 14,
  parameter int OFFSET_BINARY = 1,
  parameter int INVERT        = 1
) (
  input  logic signed [DATA_IN_SIZE-1:0] data_i,
  output logic        [DAC_SIZE-1:0]     dac_o
);

  // Largest and smallest values representable in DAC_SIZE two's complement
  localparam logic signed [DATA_IN_SIZE-1:0] c_max =
    {{(DATA_IN_SIZE-DAC_SIZE+1){1'b0}}, {(DAC_SIZE-1){1'b1}}};
  localparam logic signed [DATA_IN_SIZE-1:0] c_min =
    {{(DATA_IN_SIZE-DAC_SIZE+1){1'b1}}, {(DAC_SIZE-1){1'b0}}};

  logic [DAC_SIZE-1:0] w_clip;
  logic [DAC_SIZE-1:0] w_off;

  // Saturate to the DAC range; in-range values keep their low bits
  always_comb begin
    w_clip = data_i[DAC_SIZE-1:0];
    if (data_i > c_max) begin
      w_clip = {1'b0, {(DAC_SIZE-1){1'b1}}};
    end else if (data_i < c_min) begin
      w_clip = {1'b1, {(DAC_SIZE-1){1'b0}}};
    end
  end

  // Flipping the MSB turns two's complement into offset binary
  assign w_off = {w_clip[DAC_SIZE-1] ^ (OFFSET_BINARY != 0), w_clip[DAC_SIZE-2:0]};

  // Board-level inversion of the finished word
  assign dac_o = (INVERT != 0) ? ~w_off : w_off;

endmodule
`default_nettype wire

// File: rtl/dac_interleave_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dac_interleave_tx
//  Purpose  : Formats two signed sample streams for the DAC and interleaves
//             them onto one bus with a channel-select strobe. The block has
//             an enable/arm FSM, a zero-order hold per channel, and a
//             saturating underrun counter.
//  Revision : 1.0  initial release
// ============================================================================
module dac_interleave_tx
  import dac_tx_pkg::*;
#(
  parameter int DATA_IN_SIZE  = 16,
  parameter int DAC_SIZE      = 14,
  parameter int OFFSET_BINARY = 1,
  parameter int INVERT        = 1
) (
  input  logic                    dac_clk_i,
  input  logic                    resetn,
  input  logic                    enable_i,
  input  logic [DATA_IN_SIZE-1:0] data_a_i,
  input  logic                    data_a_en_i,
  input  logic [DATA_IN_SIZE-1:0] data_b_i,
  input  logic                    data_b_en_i,
  input  logic                    cnt_clear_i,
  output logic [DAC_SIZE-1:0]     dac_dat_o,
  output logic                    dac_sel_o,
  output logic                    running_o,
  output logic [UNDERRUN_W-1:0]   underrun_cnt_o
);

  // Formatted value of zero: the idle/mid-scale word
  localparam logic [DAC_SIZE-1:0] c_mid_pre =
    (OFFSET_BINARY != 0) ? {1'b1, {(DAC_SIZE-1){1'b0}}} : {DAC_SIZE{1'b0}};
  localparam logic [DAC_SIZE-1:0] c_mid = (INVERT != 0) ? ~c_mid_pre : c_mid_pre;

  logic [1:0]                    r_state;
  logic [1:0]                    w_state_nxt;
  logic signed [DATA_IN_SIZE-1:0] r_hold_a;
  logic signed [DATA_IN_SIZE-1:0] r_hold_b;
  logic                          r_pend_a;
  logic                          r_pend_b;
  logic                          r_phase;
  logic [DAC_SIZE-1:0]           w_fmt_a;
  logic [DAC_SIZE-1:0]           w_fmt_b;
  logic [DAC_SIZE-1:0]           r_conv_a;
  logic [DAC_SIZE-1:0]           r_conv_b;
  logic [DAC_SIZE-1:0]           r_dac_dat;
  logic                          r_dac_sel;
  logic [DAC_SIZE-1:0]           w_dat_nxt;
  logic                          w_sel_nxt;
  logic                          w_consume_a;
  logic                          w_consume_b;
  logic                          w_underrun;
  logic [UNDERRUN_W-1:0]         r_cnt;

  dac_sample_fmt #(
    .DATA_IN_SIZE  (DATA_IN_SIZE),
    .DAC_SIZE      (DAC_SIZE),
    .OFFSET_BINARY (OFFSET_BINARY),
    .INVERT        (INVERT)
  ) u_fmt_a (
    .data_i (r_hold_a),
    .dac_o  (w_fmt_a)
  );

  dac_sample_fmt #(
    .DATA_IN_SIZE  (DATA_IN_SIZE),
    .DAC_SIZE      (DAC_SIZE),
    .OFFSET_BINARY (OFFSET_BINARY),
    .INVERT        (INVERT)
  ) u_fmt_b (
    .data_i (r_hold_b),
    .dac_o  (w_fmt_b)
  );

  // State register
  always_ff @(posedge dac_clk_i) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic: arm on enable, run once both channels hold a sample
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (enable_i) w_state_nxt = ARM;
      ARM: begin
        if (!enable_i)                 w_state_nxt = IDLE;
        else if (r_pend_a && r_pend_b) w_state_nxt = RUN;
      end
      RUN:     if (!enable_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output logic: pick the channel for this phase, or mid-scale when not running
  always_comb begin
    w_dat_nxt   = c_mid;
    w_sel_nxt   = 1'b0;
    w_consume_a = 1'b0;
    w_consume_b = 1'b0;
    if (r_state == RUN && enable_i) begin
      w_dat_nxt   = r_phase ? r_conv_b : r_conv_a;
      w_sel_nxt   = r_phase;
      w_consume_a = ~r_phase;
      w_consume_b = r_phase;
    end
    // A fresh sample on the consuming edge is not an underrun
    w_underrun = (w_consume_a && !r_pend_a && !data_a_en_i) ||
                 (w_consume_b && !r_pend_b && !data_b_en_i);
  end

  // Hold registers, pending flags, phase and the formatting pipeline stage
  always_ff @(posedge dac_clk_i) begin
    if (!resetn) begin
      r_hold_a <= '0;
      r_hold_b <= '0;
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
      r_phase  <= 1'b0;
      r_conv_a <= c_mid;
      r_conv_b <= c_mid;
    end else begin
      r_conv_a <= w_fmt_a;
      r_conv_b <= w_fmt_b;
      r_phase  <= (r_state == RUN && enable_i) ? ~r_phase : 1'b0;
      if (r_state == IDLE) begin
        r_hold_a <= '0;
        r_hold_b <= '0;
        r_pend_a <= 1'b0;
        r_pend_b <= 1'b0;
      end else begin
        // A new sample takes priority over consumption
        if (data_a_en_i) begin
          r_hold_a <= data_a_i;
          r_pend_a <= 1'b1;
        end else if (w_consume_a) begin
          r_pend_a <= 1'b0;
        end
        if (data_b_en_i) begin
          r_hold_b <= data_b_i;
          r_pend_b <= 1'b1;
        end else if (w_consume_b) begin
          r_pend_b <= 1'b0;
        end
      end
    end
  end

  // Output word and strobe, registered together so they stay aligned
  always_ff @(posedge dac_clk_i) begin
    if (!resetn) begin
      r_dac_dat <= c_mid;
      r_dac_sel <= 1'b0;
    end else begin
      r_dac_dat <= w_dat_nxt;
      r_dac_sel <= w_sel_nxt;
    end
  end

  // Saturating underrun counter; an explicit clear beats an increment
  always_ff @(posedge dac_clk_i) begin
    if (!resetn || cnt_clear_i) begin
      r_cnt <= '0;
    end else if (w_underrun && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dac_dat_o      = r_dac_dat;
  assign dac_sel_o      = r_dac_sel;
  assign running_o      = (r_state == RUN);
  assign underrun_cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dac_interleave_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_interleave_tx
//  Purpose  : Directed self-checking bench for dac_interleave_tx at its
//             default parameters (16-bit in, 14-bit DAC, offset binary,
//             inverted).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dac_interleave_tx;

  logic        clk;
  logic        resetn;
  logic        enable_i;
  logic [15:0] data_a_i;
  logic        data_a_en_i;
  logic [15:0] data_b_i;
  logic        data_b_en_i;
  logic        cnt_clear_i;
  logic [13:0] dac_dat_o;
  logic        dac_sel_o;
  logic        running_o;
  logic [15:0] underrun_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  dac_interleave_tx dut (
    .dac_clk_i      (clk),
    .resetn         (resetn),
    .enable_i       (enable_i),
    .data_a_i       (data_a_i),
    .data_a_en_i    (data_a_en_i),
    .data_b_i       (data_b_i),
    .data_b_en_i    (data_b_en_i),
    .cnt_clear_i    (cnt_clear_i),
    .dac_dat_o      (dac_dat_o),
    .dac_sel_o      (dac_sel_o),
    .running_o      (running_o),
    .underrun_cnt_o (underrun_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] a, input logic [15:0] b);
    data_a_i = a; data_b_i = b; data_a_en_i = 1'b1; data_b_en_i = 1'b1;
    tick();
    data_a_en_i = 1'b0; data_b_en_i = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    resetn = 1'b1;
    repeat (10) tick();
    n_total++; if (dac_dat_o !== 14'h1FFF) $display("FAIL reset_dat: got %h want 1fff", dac_dat_o); else n_pass++;
    n_total++; if (dac_sel_o !== 1'b0) $display("FAIL reset_sel: got %b want 0", dac_sel_o); else n_pass++;
    n_total++; if (running_o !== 1'b0) $display("FAIL reset_running: got %b want 0", running_o); else n_pass++;
    n_total++; if (underrun_cnt_o !== 16'h0) $display("FAIL reset_cnt: got %h want 0", underrun_cnt_o); else n_pass++;
  endtask

  task automatic test_basic();
    enable_i = 1'b1;
    tick(); tick();                 // IDLE -> ARM, then sit in ARM
    n_total++; if (dac_dat_o !== 14'h1FFF) $display("FAIL arm_dat: got %h want 1fff", dac_dat_o); else n_pass++;
    feed(16'h0100, 16'h8000);       // capture edge n
    tick();                         // edge n+1: ARM -> RUN
    n_total++; if (running_o !== 1'b1) $display("FAIL run_entry: got %b want 1", running_o); else n_pass++;
    n_total++; if (dac_dat_o !== 14'h1FFF) $display("FAIL run_entry_dat: got %h want 1fff", dac_dat_o); else n_pass++;
    tick();                         // edge n+2: channel A
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b0, 14'h1EFF}) $display("FAIL basic_a: got %b/%h want 0/1eff", dac_sel_o, dac_dat_o); else n_pass++;
    tick();                         // edge n+3: channel B
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b1, 14'h3FFF}) $display("FAIL basic_b: got %b/%h want 1/3fff", dac_sel_o, dac_dat_o); else n_pass++;
    tick();                         // edge n+4: A underrun, held word repeats
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b0, 14'h1EFF}) $display("FAIL repeat_a: got %b/%h want 0/1eff", dac_sel_o, dac_dat_o); else n_pass++;
    n_total++; if (underrun_cnt_o !== 16'd1) $display("FAIL basic_cnt1: got %0d want 1", underrun_cnt_o); else n_pass++;
    tick();                         // edge n+5: B underrun
    n_total++; if (underrun_cnt_o !== 16'd2) $display("FAIL basic_cnt2: got %0d want 2", underrun_cnt_o); else n_pass++;
  endtask

  task automatic test_saturation();
    // Phase is 0 at the next edge, so A shows after +2 edges and B after +3
    feed(16'h7FFF, 16'h1FFF);
    tick(); tick();
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b0, 14'h0000}) $display("FAIL sat_a_pos: got %b/%h want 0/0000", dac_sel_o, dac_dat_o); else n_pass++;
    tick();
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b1, 14'h0000}) $display("FAIL sat_b_pos: got %b/%h want 1/0000", dac_sel_o, dac_dat_o); else n_pass++;
    feed(16'h9000, 16'hE000);
    tick(); tick();
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b0, 14'h3FFF}) $display("FAIL sat_a_neg: got %b/%h want 0/3fff", dac_sel_o, dac_dat_o); else n_pass++;
    tick();
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b1, 14'h3FFF}) $display("FAIL sat_b_neg: got %b/%h want 1/3fff", dac_sel_o, dac_dat_o); else n_pass++;
  endtask

  task automatic test_steady_and_underrun();
    // Clear on an edge that is also an underrun on A: clear must win
    cnt_clear_i = 1'b1;
    tick();
    cnt_clear_i = 1'b0;
    n_total++; if (underrun_cnt_o !== 16'd0) $display("FAIL clear_vs_underrun: got %0d want 0", underrun_cnt_o); else n_pass++;
    // Pairs every 2 edges; the first lands on a B consume with B empty (set wins)
    for (int i = 0; i < 50; i++) begin
      feed(16'h0100, 16'h8000);
      tick();
    end
    n_total++; if (underrun_cnt_o !== 16'd0) $display("FAIL steady_cnt: got %0d want 0", underrun_cnt_o); else n_pass++;
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b0, 14'h1EFF}) $display("FAIL steady_dat: got %b/%h want 0/1eff", dac_sel_o, dac_dat_o); else n_pass++;
    // Starve: one B still pending, then ten underrun edges
    repeat (11) tick();
    n_total++; if (underrun_cnt_o !== 16'd10) $display("FAIL starve_cnt: got %0d want 10", underrun_cnt_o); else n_pass++;
    n_total++; if ({dac_sel_o, dac_dat_o} !== {1'b1, 14'h3FFF}) $display("FAIL starve_repeat: got %b/%h want 1/3fff", dac_sel_o, dac_dat_o); else n_pass++;
    cnt_clear_i = 1'b1;
    tick();
    cnt_clear_i = 1'b0;
    n_total++; if (underrun_cnt_o !== 16'd0) $display("FAIL clear_cnt: got %0d want 0", underrun_cnt_o); else n_pass++;
  endtask

  task automatic test_disable();
    enable_i = 1'b0;
    tick();
    n_total++; if ({running_o, dac_sel_o, dac_dat_o} !== {1'b0, 1'b0, 14'h1FFF}) $display("FAIL disable: got %b/%b/%h want 0/0/1fff", running_o, dac_sel_o, dac_dat_o); else n_pass++;
    // Re-enable without new data: ARM must hold MID and never run
    enable_i = 1'b1;
    repeat (4) tick();
    n_total++; if ({running_o, dac_dat_o} !== {1'b0, 14'h1FFF}) $display("FAIL rearm_no_data: got %b/%h want 0/1fff", running_o, dac_dat_o); else n_pass++;
    // Toggle enable while armed, with a lone A sample in between
    for (int i = 0; i < 6; i++) begin
      enable_i = i[0];
      data_a_en_i = (i == 2);
      data_a_i = 16'h1234;
      tick();
      n_total++; if ({running_o, dac_sel_o, dac_dat_o} !== {1'b0, 1'b0, 14'h1FFF}) $display("FAIL arm_toggle_%0d: got %b/%b/%h want 0/0/1fff", i, running_o, dac_sel_o, dac_dat_o); else n_pass++;
    end
    data_a_en_i = 1'b0;
    enable_i = 1'b1;
    tick();
  endtask

  task automatic test_reset_midrun();
    tick();                         // ensure armed
    feed(16'h0100, 16'h8000);
    tick();                         // enter RUN
    repeat (5) tick();              // A ok, B ok, then three underruns
    n_total++; if (underrun_cnt_o !== 16'd3) $display("FAIL midrun_cnt: got %0d want 3", underrun_cnt_o); else n_pass++;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    enable_i = 1'b0;
    n_total++; if ({running_o, dac_sel_o, dac_dat_o} !== {1'b0, 1'b0, 14'h1FFF}) $display("FAIL midrun_reset_out: got %b/%b/%h want 0/0/1fff", running_o, dac_sel_o, dac_dat_o); else n_pass++;
    n_total++; if (underrun_cnt_o !== 16'd0) $display("FAIL midrun_reset_cnt: got %0d want 0", underrun_cnt_o); else n_pass++;
  endtask

  initial begin
    resetn = 1'b0; enable_i = 1'b0; cnt_clear_i = 1'b0;
    data_a_i = '0; data_b_i = '0; data_a_en_i = 1'b0; data_b_en_i = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_steady_and_underrun();
    test_disable();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
